ws2812_receiver: RTL

Single-wire WS2812 stream decoder: the receiving end of our WS2812 transmit path. It samples the serial line, classifies each high pulse as a 0 or 1 bit by width, and assembles bits MSB-first into bytes. Bytes go out as one-cycle strobes, and the end-of-frame latch gap is flagged. It serves as a bench loopback checker for the sender and as a front end for daisy-chained pixel emulation.

---
 rtl/ws2812_receiver_if.sv | 22 ++
 rtl/ws2812_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812_receiver_if.sv
// WS2812 receiver bus: serial line in, decoded byte stream and frame status out.
// With WS2812_RX_ERR_EN defined the bus also carries the err strobe.
interface ws2812_receiver_if;
    logic       din;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_end;
    logic       busy;
`ifdef WS2812_RX_ERR_EN
    logic       err;

    modport master (output din, input data_out, input data_valid, input frame_end,
                    input busy, input err);
    modport slave  (input din, output data_out, output data_valid, output frame_end,
                    output busy, output err);
`else
    modport master (output din, input data_out, input data_valid, input frame_end,
                    input busy);
    modport slave  (input din, output data_out, output data_valid, output frame_end,
                    output busy);
`endif
endinterface

// File: rtl/ws2812_receiver.sv
// WS2812 single-wire stream decoder: synchronizes din, classifies each high
// pulse as 0/1 by width, assembles MSB-first bytes and flags the latch gap.
// Optional macro WS2812_RX_ERR_EN adds illegal-pulse-width detection (err).
module ws2812_receiver #(
    parameter int INPUT_CLOCK      = 12_000_000,
    parameter int BIT_THRESHOLD_NS = 575,
`ifdef WS2812_RX_ERR_EN
    parameter int MIN_HIGH_NS      = 150,
    parameter int MAX_HIGH_NS      = 1200,
`endif
    parameter int RESET_DETECT_NS  = 50000
) (
    input  logic              clk,
    input  logic              rst,
    ws2812_receiver_if.slave  bus
);

    // Nanoseconds to cycles, truncating; 64-bit math avoids overflow.
    localparam int THRESH_CYC = int'((64'(BIT_THRESHOLD_NS) * 64'(INPUT_CLOCK)) / 64'd1_000_000_000);
    localparam int RESET_CYC  = int'((64'(RESET_DETECT_NS)  * 64'(INPUT_CLOCK)) / 64'd1_000_000_000);
    localparam int CNT_W      = $clog2(RESET_CYC + 1);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT_C    = '1;

`ifdef WS2812_RX_ERR_EN
    localparam int MIN_CYC = int'((64'(MIN_HIGH_NS) * 64'(INPUT_CLOCK)) / 64'd1_000_000_000);
    localparam int MAX_CYC = int'((64'(MAX_HIGH_NS) * 64'(INPUT_CLOCK)) / 64'd1_000_000_000);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYC);
`endif

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t             state_q, state_d;
    logic               sync_q, s_q, s_prev_q;
    logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]   low_cnt_q, low_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               busy_q, busy_d;
    logic               byte_done_q, byte_done_d;
    logic               frame_end_q, frame_end_d;
    logic               data_valid_q;
    logic [7:0]         data_out_q;
    logic               rise, fall, bit_val, pulse_bad;
`ifdef WS2812_RX_ERR_EN
    logic               err_q, err_d;
`endif

    assign rise    = s_q & ~s_prev_q;
    assign fall    = ~s_q & s_prev_q;
    assign bit_val = (high_cnt_q >= THRESH_C);
`ifdef WS2812_RX_ERR_EN
    assign pulse_bad = (high_cnt_q < MIN_C) || (high_cnt_q > MAX_C);
`else
    assign pulse_bad = 1'b0;
`endif

    // Two-flop synchronizer on din plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= bus.din;
            s_q      <= sync_q;
            s_prev_q <= s_q;
        end
    end

    // Decoder state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_GAP;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            frame_end_q <= 1'b0;
`ifdef WS2812_RX_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            frame_end_q <= frame_end_d;
`ifdef WS2812_RX_ERR_EN
            err_q       <= err_d;
`endif
        end
        shift_q <= shift_d;
    end

    // Next-state logic: pulse-width measurement, bit assembly and gap detection.
    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        byte_done_d = 1'b0;
        frame_end_d = 1'b0;
`ifdef WS2812_RX_ERR_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            WAIT_GAP: begin
                // Re-aligns to byte boundaries: only a full latch gap re-arms decoding.
                if (s_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q >= RESET_C) begin
                    state_d = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + ONE_C;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = ONE_C;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    low_cnt_d = ONE_C;
                    if (pulse_bad) begin
`ifdef WS2812_RX_ERR_EN
                        err_d = 1'b1;
`endif
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WAIT_GAP;
                    end else begin
                        shift_d     = {shift_q[6:0], bit_val};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                        state_d     = LOW;
                    end
                end else if (high_cnt_q != SAT_C) begin
                    high_cnt_d = high_cnt_q + ONE_C;
                end
            end
            LOW: begin
                // A rise always wins over a gap that would complete this cycle.
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = ONE_C;
                end else if (low_cnt_q >= RESET_C) begin
                    frame_end_d = 1'b1;
                    busy_d      = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + ONE_C;
                end
            end
            default: state_d = WAIT_GAP;
        endcase
    end

    // Output register: publish a completed byte one cycle after its last fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= byte_done_q;
            if (byte_done_q) begin
                data_out_q <= shift_q;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_end  = frame_end_q;
    assign bus.busy       = busy_q;
`ifdef WS2812_RX_ERR_EN
    assign bus.err        = err_q;
`endif

endmodule
